// File: rtl/tblink_rpc_hdl_pkg.sv
// Shared types for the tblink RPC HDL call path.
//  - Default payload widths (method id, call id, parameters, return value).
//  - call_req_t: one buffered invocation as it sits in the request FIFO.
//  - slot_state_t: occupancy state of an outstanding-call slot.
package tblink_rpc_hdl_pkg;

    localparam int MID_W    = 8;
    localparam int PARAM_W  = 64;
    localparam int RET_W    = 64;
    localparam int CALLID_W = 64;

    typedef struct packed {
        logic [MID_W-1:0]    method_id;
        logic [CALLID_W-1:0] call_id;
        logic [PARAM_W-1:0]  params;
    } call_req_t;

    typedef enum logic {
        SLOT_FREE = 1'b0,
        SLOT_BUSY = 1'b1
    } slot_state_t;

endpackage

// File: rtl/tblink_rpc_call_queue_chk.sv
// Protocol checker for the call queue.
// Ports: clock, reset_n, FIFO push/pop/full/empty strobes, outstanding count.
module tblink_rpc_call_queue_chk #(
    parameter int N_SLOTS = 4,
    parameter int TAG_W   = 2
) (
    input logic           clock,
    input logic           reset_n,
    input logic           push,
    input logic           pop,
    input logic           full,
    input logic           empty,
    input logic [TAG_W:0] outstanding
);

    a_no_push_full: assert property (@(posedge clock) disable iff (!reset_n) !(push && full));
    a_no_pop_empty: assert property (@(posedge clock) disable iff (!reset_n) !(pop && empty));
    a_outstanding:  assert property (@(posedge clock) disable iff (!reset_n)
                                     outstanding <= (TAG_W+1)'(N_SLOTS));

endmodule

// File: rtl/tblink_rpc_sync_fifo.sv
// Synchronous FIFO holding pending invocations.
// Ports:
//  clock, reset_n : clock and async active-low reset
//  push, wdata    : write strobe and data (ignored when full)
//  pop            : read strobe (ignored when empty)
//  rdata          : head entry, read from the storage registers
//  full, empty    : status from wrap-bit pointer comparison
// A pushed entry lands in storage on the clock edge, so it appears at rdata
// one cycle after the push at the earliest.
module tblink_rpc_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    // Same index with differing wrap bits means the write side has lapped the read side.
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer and storage update; storage is cleared so outputs read zero after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= wdata;
                wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/tblink_rpc_call_queue.sv
// Call queue between the DPI invoke shim and a BFM.
// Ports:
//  req_*        : inbound invocations from the shim (valid/ready)
//  inv_*        : invocations issued to the BFM with a slot tag (valid/ready)
//  rsp_*        : BFM responses by tag, any order (valid/ready)
//  out_*        : completions (call id + return value) back to the shim
//  outstanding  : number of busy slots
//  err_bad_tag  : one-cycle pulse when a response names a free slot
module tblink_rpc_call_queue
    import tblink_rpc_hdl_pkg::*;
#(
    parameter int  DEPTH    = 4,
    parameter int  N_SLOTS  = 4,
    parameter int  MID_W    = tblink_rpc_hdl_pkg::MID_W,
    parameter int  PARAM_W  = tblink_rpc_hdl_pkg::PARAM_W,
    parameter int  RET_W    = tblink_rpc_hdl_pkg::RET_W,
    parameter int  CALLID_W = tblink_rpc_hdl_pkg::CALLID_W,
    localparam int TAG_W    = $clog2(N_SLOTS)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [MID_W-1:0]    req_method_id,
    input  logic [CALLID_W-1:0] req_call_id,
    input  logic [PARAM_W-1:0]  req_params,
    output logic                inv_valid,
    input  logic                inv_ready,
    output logic [MID_W-1:0]    inv_method_id,
    output logic [PARAM_W-1:0]  inv_params,
    output logic [TAG_W-1:0]    inv_tag,
    input  logic                rsp_valid,
    output logic                rsp_ready,
    input  logic [TAG_W-1:0]    rsp_tag,
    input  logic [RET_W-1:0]    rsp_retval,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CALLID_W-1:0] out_call_id,
    output logic [RET_W-1:0]    out_retval,
    output logic [TAG_W:0]      outstanding,
    output logic                err_bad_tag
);

    call_req_t           fifo_wdata_s;
    call_req_t           fifo_rdata_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic                push_s;

    slot_state_t         slot_r     [N_SLOTS];
    logic [CALLID_W-1:0] slot_cid_r [N_SLOTS];
    logic [N_SLOTS-1:0]  busy_s;
    logic [N_SLOTS-1:0]  busy_nxt_s;
    logic [TAG_W-1:0]    free_tag_s;
    logic                any_free_s;
    logic [TAG_W-1:0]    inv_tag_s;
    logic                inv_valid_s;
    logic                issue_fire_s;
    logic                rsp_ready_s;
    logic                rsp_fire_s;
    logic                rsp_hit_s;
    logic [TAG_W:0]      busy_cnt_nxt_s;

    logic                hold_r;
    logic [TAG_W-1:0]    hold_tag_r;
    logic                out_valid_r;
    logic [CALLID_W-1:0] out_call_id_r;
    logic [RET_W-1:0]    out_retval_r;
    logic [TAG_W:0]      outstanding_r;
    logic                err_bad_tag_r;

    assign fifo_wdata_s = '{method_id: req_method_id, call_id: req_call_id, params: req_params};
    assign push_s       = req_valid && !fifo_full_s;

    tblink_rpc_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(call_req_t))
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push_s),
        .wdata   (fifo_wdata_s),
        .pop     (issue_fire_s),
        .rdata   (fifo_rdata_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Slot occupancy and lowest-index free slot, taken from the registered state.
    always_comb begin
        free_tag_s = '0;
        any_free_s = 1'b0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            busy_s[i]  = (slot_r[i] == SLOT_BUSY);
            free_tag_s = busy_s[i] ? free_tag_s : TAG_W'(i);
            any_free_s = any_free_s || !busy_s[i];
        end
    end

    // A stalled offer keeps its tag even if a lower slot frees meanwhile,
    // so the BFM sees stable inv_* until it accepts.
    assign inv_tag_s    = hold_r ? hold_tag_r : free_tag_s;
    assign inv_valid_s  = !fifo_empty_s && any_free_s;
    assign issue_fire_s = inv_valid_s && inv_ready;
    assign rsp_ready_s  = !out_valid_r || out_ready;
    assign rsp_fire_s   = rsp_valid && rsp_ready_s;
    assign rsp_hit_s    = rsp_fire_s && busy_s[rsp_tag];

    // Next occupancy and its popcount; allocated and freed slots are always distinct.
    always_comb begin
        busy_cnt_nxt_s = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            busy_nxt_s[i]  = (busy_s[i] || (issue_fire_s && (inv_tag_s == TAG_W'(i))))
                             && !(rsp_hit_s && (rsp_tag == TAG_W'(i)));
            busy_cnt_nxt_s = busy_cnt_nxt_s + (TAG_W+1)'(busy_nxt_s[i]);
        end
    end

    // Slot table, completion register, error pulse and offer hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                slot_r[i]     <= SLOT_FREE;
                slot_cid_r[i] <= '0;
            end
            hold_r        <= 1'b0;
            hold_tag_r    <= '0;
            out_valid_r   <= 1'b0;
            out_call_id_r <= '0;
            out_retval_r  <= '0;
            outstanding_r <= '0;
            err_bad_tag_r <= 1'b0;
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                slot_r[i] <= busy_nxt_s[i] ? SLOT_BUSY : SLOT_FREE;
            end
            if (issue_fire_s) begin
                slot_cid_r[inv_tag_s] <= fifo_rdata_s.call_id;
            end
            hold_r     <= inv_valid_s && !inv_ready;
            hold_tag_r <= inv_tag_s;
            if (rsp_hit_s) begin
                out_valid_r   <= 1'b1;
                out_call_id_r <= slot_cid_r[rsp_tag];
                out_retval_r  <= rsp_retval;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
            outstanding_r <= busy_cnt_nxt_s;
            err_bad_tag_r <= rsp_fire_s && !busy_s[rsp_tag];
        end
    end

    assign req_ready     = !fifo_full_s;
    assign inv_valid     = inv_valid_s;
    assign inv_method_id = fifo_rdata_s.method_id;
    assign inv_params    = fifo_rdata_s.params;
    assign inv_tag       = inv_tag_s;
    assign rsp_ready     = rsp_ready_s;
    assign out_valid     = out_valid_r;
    assign out_call_id   = out_call_id_r;
    assign out_retval    = out_retval_r;
    assign outstanding   = outstanding_r;
    assign err_bad_tag   = err_bad_tag_r;

    tblink_rpc_call_queue_chk #(
        .N_SLOTS (N_SLOTS),
        .TAG_W   (TAG_W)
    ) u_chk (
        .clock       (clock),
        .reset_n     (reset_n),
        .push        (push_s),
        .pop         (issue_fire_s),
        .full        (fifo_full_s),
        .empty       (fifo_empty_s),
        .outstanding (outstanding_r)
    );

endmodule
